seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter DIGIT_HZ, default 1000, meaning the per-digit dwell rate; DIV = CLK_HZ/DIGIT_HZ cycles per digit, with DIV >= 2.
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, meaning frames per blink half-period, >= 1.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all logic rises on its edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port load, input, 1 bit: a one-cycle strobe that captures chars and blink_mask into the shadow buffer.
REQ-007 SHALL have port chars, input, 40 bits: eight 5-bit character codes; chars[4:0] is digit 0 (rightmost) and chars[39:35] is digit 7 (leftmost).
REQ-008 SHALL have port blink_mask, input, 8 bits: bit i set makes digit i blink.
REQ-009 SHALL have port an, output, 8 bits: active-low anode enables, registered.
REQ-010 SHALL have port seg, output, 7 bits: active-low segments {g,f,e,d,c,b,a}, registered.
REQ-011 SHALL have port dp, output, 1 bit: decimal point, constant 1 (off).
REQ-012 SHALL have port frame_done, output, 1 bit: a one-cycle pulse at the end of each 8-digit frame.

Function
REQ-013 SHALL decode character codes as follows:
- 0x00-0x09 → digits 0-9
- 0x0A A, 0x0B b, 0x0C C, 0x0D L, 0x0E Y, 0x0F G, 0x10 J, 0x11 S, 0x12 E, 0x13 t, 0x14 U, 0x15 P, 0x16 '-'
- any other code → blank (seg 0x7F)
REQ-014 SHALL produce these required seg values: '0'=0x40, '1'=0x79, 'E'=0x06, 'J'=0x61, 'P'=0x0C, '-'=0x3F, blank=0x7F.
REQ-015 SHALL hold two buffers (active and shadow), each containing chars plus blink_mask, and a pending flag.
REQ-016 SHALL, when load=1, capture inputs into shadow and set pending on that edge; a later load before commit overwrites shadow (last write wins).
REQ-017 SHALL, at the frame boundary (last cycle of digit 7 dwell), copy shadow to active if pending and clear pending; active never changes mid-frame (no tearing).
REQ-018 SHALL, when load coincides with the frame boundary, commit the pre-edge shadow to active, write the new data to shadow, and leave pending at 1.
REQ-019 SHALL scan with a prescaler p counting 0..DIV-1 and a digit index idx counting 0..7; idx increments when p = DIV-1, wrapping 7→0.
REQ-020 SHALL make each dwell DIV cycles long:
- first cycle (guard): an=0xFF, seg=0x7F
- remaining DIV-1 cycles: an has only bit idx low, seg = decode(active char idx)
REQ-021 SHALL register outputs so that an, seg and frame_done are mutually cycle-aligned; frame_done=1 exactly in the last cycle of digit 7 dwell, i.e. once every 8*DIV cycles.
REQ-022 SHALL toggle blink phase at frame_done when the frame counter reaches BLINK_FRAMES-1, then clear that counter.
REQ-023 SHALL, while phase=1 and an active blink_mask bit is set, show seg=0x7F for that digit; anode timing is unchanged.
REQ-024 SHALL not let load affect the prescaler, idx, phase or the frame counter.

Reset
REQ-025 SHALL, with reset=0 at a clock edge, set p=0, idx=0, active and shadow chars to 0x1F (blank), masks to 0, pending=0, phase=0 and frame counter=0.
REQ-026 SHALL hold outputs at an=0xFF, seg=0x7F, dp=1, frame_done=0 throughout reset and in the first cycle after release (guard of digit 0).
REQ-027 SHALL, on reset asserted mid-frame or with pending=1, discard the shadow and pending without committing, and restart the scan at digit 0 on release.

Verification (CLK_HZ=800, DIGIT_HZ=100 → DIV=8; BLINK_FRAMES=2)
REQ-028 SHALL cover: after reset release, no load → an cycles FF,FE×7,FF,FD×7,…,FF,7F×7, seg always 0x7F, frame_done pulses every 64 cycles.
REQ-029 SHALL cover: load chars={0x10,0x01,0x1F,0x11,0x12,0x13,0x14,0x15} (digit 7..0) at cycle 10 → display unchanged until the first frame_done; next frame digit 0 shows seg 0x0C ('P') and digit 7 shows 0x61 ('J').
REQ-030 SHALL cover: two loads (all '1', then all '0') in one frame → next frame shows only 0x40; 0x79 never appears.
REQ-031 SHALL cover: a load coinciding with frame_done → the earlier shadow appears in the next frame, the new data in the frame after.
REQ-032 SHALL cover: blink_mask=0x01 committed → digit 0 shows its char for frames 0-1, blank for frames 2-3, then repeats; other digits are steady.
REQ-033 SHALL cover: reset asserted at cycle 100 with pending=1 → after release, outputs are blank and the pending data is never displayed.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment scanner with double-buffered character
// data committed only at frame boundaries, per-digit blink and a guard cycle per dwell.
module seg7_scan_driver #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [39:0] chars,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int DIV = CLK_HZ / DIGIT_HZ;
    localparam int P_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int F_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [P_W-1:0] P_LAST      = P_W'(DIV - 1);
    localparam logic [F_W-1:0] F_LAST      = F_W'(BLINK_FRAMES - 1);
    localparam logic [39:0]    BLANK_CHARS = {8{5'h1F}};
    localparam logic [6:0]     SEG_BLANK   = 7'h7F;
    localparam logic [7:0]     AN_OFF      = 8'hFF;

    // Segment patterns are active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'h00:   s = 7'h40;
            5'h01:   s = 7'h79;
            5'h02:   s = 7'h24;
            5'h03:   s = 7'h30;
            5'h04:   s = 7'h19;
            5'h05:   s = 7'h12;
            5'h06:   s = 7'h02;
            5'h07:   s = 7'h78;
            5'h08:   s = 7'h00;
            5'h09:   s = 7'h10;
            5'h0A:   s = 7'h08;
            5'h0B:   s = 7'h03;
            5'h0C:   s = 7'h46;
            5'h0D:   s = 7'h47;
            5'h0E:   s = 7'h11;
            5'h0F:   s = 7'h42;
            5'h10:   s = 7'h61;
            5'h11:   s = 7'h12;
            5'h12:   s = 7'h06;
            5'h13:   s = 7'h07;
            5'h14:   s = 7'h41;
            5'h15:   s = 7'h0C;
            5'h16:   s = 7'h3F;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    logic [P_W-1:0] p_q, p_d;
    logic [2:0]     idx_q, idx_d;
    logic [39:0]    act_chars_q, act_chars_d;
    logic [7:0]     act_mask_q, act_mask_d;
    logic [39:0]    sh_chars_q, sh_chars_d;
    logic [7:0]     sh_mask_q, sh_mask_d;
    logic           pend_q, pend_d;
    logic           phase_q, phase_d;
    logic [F_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]     an_q, an_d;
    logic [6:0]     seg_q, seg_d;
    logic           fd_q, fd_d;
    logic           last_p_s;
    logic           boundary_s;
    logic [4:0]     cur_char_s;
    logic           cur_blank_s;

    // Character of the digit currently being scanned.
    always_comb begin
        cur_char_s = 5'h1F;
        case (idx_q)
            3'd0:    cur_char_s = act_chars_q[4:0];
            3'd1:    cur_char_s = act_chars_q[9:5];
            3'd2:    cur_char_s = act_chars_q[14:10];
            3'd3:    cur_char_s = act_chars_q[19:15];
            3'd4:    cur_char_s = act_chars_q[24:20];
            3'd5:    cur_char_s = act_chars_q[29:25];
            3'd6:    cur_char_s = act_chars_q[34:30];
            3'd7:    cur_char_s = act_chars_q[39:35];
            default: cur_char_s = 5'h1F;
        endcase
    end

    // Next-state: scan counters, buffer commit, blink phase and output images.
    always_comb begin
        last_p_s    = (p_q == P_LAST);
        boundary_s  = last_p_s && (idx_q == 3'd7);
        cur_blank_s = phase_q & act_mask_q[idx_q];

        p_d         = p_q;
        idx_d       = idx_q;
        act_chars_d = act_chars_q;
        act_mask_d  = act_mask_q;
        sh_chars_d  = sh_chars_q;
        sh_mask_d   = sh_mask_q;
        pend_d      = pend_q;
        phase_d     = phase_q;
        fcnt_d      = fcnt_q;
        an_d        = AN_OFF;
        seg_d       = SEG_BLANK;
        fd_d        = boundary_s;

        if (last_p_s) begin
            p_d   = {P_W{1'b0}};
            idx_d = idx_q + 3'd1;
        end else begin
            p_d   = p_q + P_W'(1);
            idx_d = idx_q;
        end

        // Commit uses the pre-edge shadow, so a coincident load lands in shadow and stays pending.
        if (boundary_s && pend_q) begin
            act_chars_d = sh_chars_q;
            act_mask_d  = sh_mask_q;
        end else begin
            act_chars_d = act_chars_q;
            act_mask_d  = act_mask_q;
        end

        if (load) begin
            sh_chars_d = chars;
            sh_mask_d  = blink_mask;
            pend_d     = 1'b1;
        end else if (boundary_s) begin
            pend_d     = 1'b0;
        end else begin
            pend_d     = pend_q;
        end

        if (boundary_s) begin
            if (fcnt_q == F_LAST) begin
                phase_d = ~phase_q;
                fcnt_d  = {F_W{1'b0}};
            end else begin
                fcnt_d  = fcnt_q + F_W'(1);
            end
        end else begin
            fcnt_d = fcnt_q;
        end

        // First cycle of every dwell is a dark guard cycle to avoid ghosting.
        if (p_q == {P_W{1'b0}}) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end else begin
            an_d  = ~(8'b0000_0001 << idx_q);
            if (cur_blank_s) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = decode(cur_char_s);
            end
        end
    end

    // State and registered-output update; reset restores a blank, idle display.
    always_ff @(posedge clock) begin
        if (!reset) begin
            p_q         <= {P_W{1'b0}};
            idx_q       <= 3'd0;
            act_chars_q <= BLANK_CHARS;
            act_mask_q  <= 8'h00;
            sh_chars_q  <= BLANK_CHARS;
            sh_mask_q   <= 8'h00;
            pend_q      <= 1'b0;
            phase_q     <= 1'b0;
            fcnt_q      <= {F_W{1'b0}};
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            fd_q        <= 1'b0;
        end else begin
            p_q         <= p_d;
            idx_q       <= idx_d;
            act_chars_q <= act_chars_d;
            act_mask_q  <= act_mask_d;
            sh_chars_q  <= sh_chars_d;
            sh_mask_q   <= sh_mask_d;
            pend_q      <= pend_d;
            phase_q     <= phase_d;
            fcnt_q      <= fcnt_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            fd_q        <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = 1'b1;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIV=8, BLINK_FRAMES=2): a per-cycle scoreboard
// fed by a behavioural model, plus scenario tasks with directed constant checks.
module tb_seg7_scan_driver;

    logic        clock;
    logic        reset;
    logic        load;
    logic [39:0] chars;
    logic [7:0]  blink_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int since_rel = -1;

    logic [15:0] sb [$];
    logic [15:0] exp_v;
    logic [6:0]  dec_tab [32];

    int          m_p, m_idx, m_fcnt;
    logic [39:0] m_act, m_sh;
    logic [7:0]  m_mask, m_shm;
    logic        m_pend, m_phase;

    seg7_scan_driver #(
        .CLK_HZ(800),
        .DIGIT_HZ(100),
        .BLINK_FRAMES(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .load(load),
        .chars(chars),
        .blink_mask(blink_mask),
        .an(an),
        .seg(seg),
        .dp(dp),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: compare each cycle's outputs with the expectation pushed at drive time.
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            checks++;
            if ({an, seg, frame_done} !== exp_v) begin
                errors++;
                $display("FAIL scoreboard t=%0t: got an=%h seg=%h fd=%b, required an=%h seg=%h fd=%b",
                         $time, an, seg, frame_done, exp_v[15:8], exp_v[7:1], exp_v[0]);
            end
        end
    end

    function automatic int lit_digit(input logic [7:0] a);
        int r;
        r = -1;
        for (int i = 0; i < 8; i++) begin
            if (a == ~(8'h01 << i)) r = i;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_p = 0; m_idx = 0; m_fcnt = 0;
        m_act = {8{5'h1F}}; m_sh = {8{5'h1F}};
        m_mask = 8'h00; m_shm = 8'h00;
        m_pend = 1'b0; m_phase = 1'b0;
    endtask

    // One clock: drive inputs, predict the outputs after the edge, advance the model.
    task automatic tick(input logic ld, input logic [39:0] ch, input logic [7:0] mk, input logic rst);
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       bnd;
        @(negedge clock);
        reset = rst; load = ld; chars = ch; blink_mask = mk;
        if (!rst) begin
            e_an = 8'hFF; e_seg = 7'h7F; bnd = 1'b0;
            model_reset();
            since_rel = -1;
        end else begin
            bnd = (m_p == 7) && (m_idx == 7);
            e_an = 8'hFF; e_seg = 7'h7F;
            if (m_p != 0) begin
                e_an[m_idx] = 1'b0;
                if (!(m_phase && m_mask[m_idx])) e_seg = dec_tab[m_act[m_idx*5 +: 5]];
            end
            if (bnd && m_pend) begin
                m_act = m_sh; m_mask = m_shm;
            end
            if (ld) begin
                m_sh = ch; m_shm = mk; m_pend = 1'b1;
            end else if (bnd) begin
                m_pend = 1'b0;
            end
            if (bnd) begin
                if (m_fcnt == 1) begin
                    m_phase = ~m_phase; m_fcnt = 0;
                end else begin
                    m_fcnt = m_fcnt + 1;
                end
            end
            if (m_p == 7) begin
                m_p = 0; m_idx = (m_idx + 1) % 8;
            end else begin
                m_p = m_p + 1;
            end
            since_rel++;
        end
        sb.push_back({e_an, e_seg, bnd});
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 40'h0, 8'h00, 1'b1);
    endtask

    task automatic idle_to_frame_end();
        idle(63 - (since_rel % 64));
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 40'h0, 8'h00, 1'b0);
            checks++;
            if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: an=%h seg=%h dp=%b fd=%b, required an=ff seg=7f dp=1 fd=0",
                         an, seg, dp, frame_done);
            end
        end
        tick(1'b0, 40'h0, 8'h00, 1'b1);
        checks++;
        if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_guard: an=%h seg=%h dp=%b fd=%b, required an=ff seg=7f dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
    endtask

    task automatic test_scan_blank();
        int pos;
        logic [7:0] e_an;
        for (int i = 0; i < 191; i++) begin
            idle(1);
            pos = since_rel % 64;
            e_an = 8'h01;
            e_an = (pos % 8 == 0) ? 8'hFF : ~(e_an << (pos / 8));
            checks++;
            if (an !== e_an || seg !== 7'h7F || frame_done !== (pos == 63)) begin
                errors++;
                $display("FAIL scan_blank pos=%0d: an=%h seg=%h fd=%b, required an=%h seg=7f fd=%b",
                         pos, an, seg, frame_done, e_an, (pos == 63));
            end
        end
    endtask

    task automatic test_load_commit();
        logic [6:0] exp_tab [8];
        int d;
        exp_tab = '{7'h0C, 7'h41, 7'h07, 7'h06, 7'h12, 7'h7F, 7'h79, 7'h61};
        idle(9);
        tick(1'b1, {5'h10, 5'h01, 5'h1F, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15}, 8'h00, 1'b1);
        while (since_rel % 64 != 63) begin
            idle(1);
            checks++;
            if (seg !== 7'h7F) begin
                errors++;
                $display("FAIL load_no_tear: seg=%h, required 7f before frame end", seg);
            end
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL load_frame_done: fd=%b, required 1", frame_done);
        end
        for (int i = 0; i < 64; i++) begin
            idle(1);
            d = lit_digit(an);
            if (d >= 0) begin
                checks++;
                if (seg !== exp_tab[d]) begin
                    errors++;
                    $display("FAIL load_commit digit %0d: seg=%h, required %h", d, seg, exp_tab[d]);
                end
            end
        end
    endtask

    task automatic test_last_write_wins();
        idle(5);
        tick(1'b1, {8{5'h01}}, 8'h00, 1'b1);
        idle(3);
        tick(1'b1, {8{5'h00}}, 8'h00, 1'b1);
        idle_to_frame_end();
        for (int i = 0; i < 64; i++) begin
            idle(1);
            if (lit_digit(an) >= 0) begin
                checks++;
                if (seg !== 7'h40) begin
                    errors++;
                    $display("FAIL last_write_wins: seg=%h, required 40", seg);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        idle(4);
        tick(1'b1, {8{5'h02}}, 8'h00, 1'b1);
        idle(62 - (since_rel % 64));
        tick(1'b1, {8{5'h03}}, 8'h00, 1'b1);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_boundary: fd=%b, required 1 on coincident load", frame_done);
        end
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 64; i++) begin
                idle(1);
                if (lit_digit(an) >= 0) begin
                    checks++;
                    if (seg !== ((f == 0) ? 7'h24 : 7'h30)) begin
                        errors++;
                        $display("FAIL b2b_frame%0d: seg=%h, required %h", f, seg,
                                 (f == 0) ? 7'h24 : 7'h30);
                    end
                end
            end
        end
    endtask

    task automatic test_blink();
        int d;
        int fr;
        logic [6:0] e_seg;
        idle(3);
        tick(1'b1, {{7{5'h00}}, 5'h01}, 8'h01, 1'b1);
        idle_to_frame_end();
        for (int i = 0; i < 256; i++) begin
            idle(1);
            d = lit_digit(an);
            fr = since_rel / 64;
            if (d >= 0) begin
                e_seg = (d != 0) ? 7'h40 : (((fr / 2) % 2 == 1) ? 7'h7F : 7'h79);
                checks++;
                if (seg !== e_seg) begin
                    errors++;
                    $display("FAIL blink frame %0d digit %0d: seg=%h, required %h", fr, d, seg, e_seg);
                end
            end
        end
    endtask

    task automatic test_reset_pending();
        int pos;
        logic [7:0] e_an;
        idle(10);
        tick(1'b1, {8{5'h09}}, 8'h00, 1'b1);
        idle(5);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 40'h0, 8'h00, 1'b0);
            checks++;
            if (an !== 8'hFF || seg !== 7'h7F || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL midframe_reset: an=%h seg=%h fd=%b, required an=ff seg=7f fd=0",
                         an, seg, frame_done);
            end
        end
        for (int i = 0; i < 128; i++) begin
            idle(1);
            pos = since_rel % 64;
            e_an = 8'h01;
            e_an = (pos % 8 == 0) ? 8'hFF : ~(e_an << (pos / 8));
            checks++;
            if (an !== e_an || seg !== 7'h7F) begin
                errors++;
                $display("FAIL pending_discard pos=%0d: an=%h seg=%h, required an=%h seg=7f",
                         pos, an, seg, e_an);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dec_tab[i] = 7'h7F;
        dec_tab[0]  = 7'h40; dec_tab[1]  = 7'h79; dec_tab[2]  = 7'h24; dec_tab[3]  = 7'h30;
        dec_tab[4]  = 7'h19; dec_tab[5]  = 7'h12; dec_tab[6]  = 7'h02; dec_tab[7]  = 7'h78;
        dec_tab[8]  = 7'h00; dec_tab[9]  = 7'h10; dec_tab[10] = 7'h08; dec_tab[11] = 7'h03;
        dec_tab[12] = 7'h46; dec_tab[13] = 7'h47; dec_tab[14] = 7'h11; dec_tab[15] = 7'h42;
        dec_tab[16] = 7'h61; dec_tab[17] = 7'h12; dec_tab[18] = 7'h06; dec_tab[19] = 7'h07;
        dec_tab[20] = 7'h41; dec_tab[21] = 7'h0C; dec_tab[22] = 7'h3F;
        model_reset();
        reset = 1'b0; load = 1'b0; chars = 40'h0; blink_mask = 8'h00;

        test_reset();
        test_scan_blank();
        test_load_commit();
        test_last_write_wins();
        test_back_to_back();
        test_blink();
        test_reset_pending();

        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
